bitbang_tx_fifo: RTL and testbench
==================================

# bitbang_tx_fifo

Parametrised, FIFO-buffered serial transmitter shifted by an externally supplied bit clock (TxC). The host pushes words into an internal FIFO. Each synchronised rising edge of TxC advances the line by one bit. A frame is a start bit, data bits, an optional parity bit and optional stop bits. It is the next generation of the single-byte bitbang transmitter in the miner FPGA's host link: configurable width, bit order, parity and stop bits, back-to-back frames from a FIFO, a flush control and overflow reporting.

## Interface
Parameters:
- DATA_W, 8, data bits per frame (1..16).
- FIFO_DEPTH, 4, FIFO entries; power of two, at least 2.
- MSB_FIRST, 0, 0 = bit 0 sent first, 1 = bit DATA_W-1 sent first.
- PARITY_EN, 0, 1 = append one parity bit after the data.
- PARITY_ODD, 0, 0 = even parity, 1 = odd parity (ignored if PARITY_EN=0).
- STOP_BITS, 0, number of idle-level (0) bits appended to each frame (0..2).

Ports:
- clk  in  1  system clock.
- TxR_n  in  1  reset; asynchronous assert, active-low.
- TxC  in  1  external bit clock; asynchronous to clk.
- flush  in  1  synchronous clear: empties the FIFO and aborts the current frame.
- TxD_start  in  1  push strobe; the word is accepted only when TxD_ready=1.
- TxD_data  in  DATA_W  word to push.
- TxD_ready  out  1  FIFO not full.
- TxD_busy  out  1  FIFO non-empty or a frame in progress.
- TxD  out  1  serial line; idle level is 0, start bit is 1.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  number of words currently stored.
- ovf  out  1  sticky flag, set when TxD_start=1 while TxD_ready=0; cleared by flush or reset.

## Operation
- TxC passes through a two-flop synchroniser and then a delay flop. tick = sync & ~sync_d, one clk cycle wide.
- State machine states: IDLE, DATA, PARITY, STOP. All transitions happen only on tick, except flush and reset.
- IDLE on tick:
  - FIFO non-empty: pop the head into the shift register, TxD<=1 (start bit), bit counter<=0, go to DATA.
  - FIFO empty: TxD<=0, stay in IDLE.
- DATA on tick:
  - TxD <= the next data bit, in the order set by MSB_FIRST; increment the counter.
  - After bit DATA_W-1: go to PARITY if PARITY_EN; otherwise go to STOP if STOP_BITS>0; otherwise go to IDLE.
- PARITY on tick: TxD <= XOR of the data bits, inverted if PARITY_ODD. Then go to STOP if STOP_BITS>0, else IDLE.
- STOP on tick: TxD<=0. After STOP_BITS ticks, go to IDLE.
- Frame length is 1 + DATA_W + PARITY_EN + STOP_BITS ticks. The first tick in IDLE after a frame starts the next frame if data is waiting; there is no gap tick beyond STOP_BITS.
- FIFO rules:
  - A push is accepted when TxD_start & TxD_ready.
  - A pop occurs only on an IDLE tick with the FIFO non-empty.
  - A push and a pop in the same cycle leave fifo_level unchanged.
  - When full, a same-cycle pop does not enable a push; TxD_ready is the registered not-full state.
- flush (synchronous, highest priority after reset): FIFO empty, state IDLE, TxD<=0, ovf<=0, counter<=0. A push in the same cycle is discarded.
- Reset mid-frame: the frame is abandoned immediately and all registers take their reset values.

## Timing
- Reset values: TxD=0, TxD_ready=1, TxD_busy=0, fifo_level=0, ovf=0, state IDLE, synchroniser flops 0.
- TxC rising edge to TxD change: 3 clk cycles (2 synchroniser cycles + 1 register cycle), ±1 cycle of sampling jitter.
- TxC high and low phases must each be at least 3 clk periods; faster TxC is out of specification.
- Push to fifo_level update: 1 cycle. Push to TxD_busy=1: 1 cycle.
- TxD_busy falls in the cycle after the final tick of a frame if the FIFO is empty.
- fifo_level wraps correctly through the pointer wrap at FIFO_DEPTH. Pointers are $clog2(FIFO_DEPTH)+1 bits wide, so full and empty are distinguished.

## Structure
- Shared package bitbang_pkg holds:
  - the state encoding constants (IDLE, DATA, PARITY, STOP);
  - a parity function (data, odd) returning 1 bit.
- Sub-module bitbang_fifo: a synchronous FIFO parametrised by width and depth, with push, pop, flush, full, empty and level. The top level contains the synchroniser, the edge detector, the state machine and the shifter.

## Test plan
- Defaults, push 0xA5, 10 TxC pulses: TxD per tick = 1,1,0,1,0,0,1,0,1, then 0; TxD_busy=0 after the 9th tick.
- MSB_FIRST=1, push 0x01, 9 pulses: TxD = 1,0,0,0,0,0,0,0,1; parity behaviour matches the defaults.
- PARITY_EN=1 and STOP_BITS=2, push 0xA5:
  - PARITY_ODD=0: 12-tick frame, parity bit 0, then 0,0.
  - PARITY_ODD=1: parity bit 1.
- FIFO_DEPTH=4, 5 pushes with no TxC: TxD_ready=0 after the 4th push, the 5th push is dropped, ovf=1, fifo_level=4.
  - 36 pulses then emit 4 back-to-back frames, each starting with a 1.
- Push 0x3C, apply 4 ticks, then assert flush: TxD=0 the next cycle, fifo_level=0, ovf=0.
  - A new push of 0x81 then transmits 1,1,0,0,0,0,0,0,1.
- Assert TxR_n low asynchronously mid-frame: TxD=0, TxD_busy=0 and TxD_ready=1 with no clk edge required.

Source files
------------

// File: rtl/bitbang_pkg.sv
// Shared definitions for the FIFO-buffered bitbang transmitter.
// State encodings and the parity helper live here.
package bitbang_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_DATA   = 2'd1;
    localparam logic [1:0] ST_PARITY = 2'd2;
    localparam logic [1:0] ST_STOP   = 2'd3;

    // Parity over a zero-extended word; odd=1 inverts the even result.
    function automatic logic parity(input logic [15:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/bitbang_fifo.sv
// Synchronous FIFO with wrap-bit pointers so full and empty are distinct.
// Flush empties it and wins over a same-cycle push or pop.
module bitbang_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush_i,
    input  logic                     push_i,
    input  logic [W-1:0]             wdata_i,
    input  logic                     pop_i,
    output logic [W-1:0]             rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   level_o
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW:0]   wr_ptr_q, wr_ptr_d;
    logic [AW:0]   rd_ptr_q, rd_ptr_d;
    logic          do_push, do_pop;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign level_o = wr_ptr_q - rd_ptr_q;
    assign rdata_o = mem[rd_ptr_q[AW-1:0]];

    assign do_push = push_i & ~full_o & ~flush_i;
    assign do_pop  = pop_i & ~empty_o & ~flush_i;

    // Next pointer values; flush collapses both pointers to zero.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    // Pointer registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage array; contents need no reset since pointers gate reads.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_q[AW-1:0]] <= wdata_i;
    end

endmodule

// File: rtl/bitbang_tx_fifo.sv
// FIFO-buffered serial transmitter advanced by an external bit clock.
// Frame: start(1), data, optional parity, optional stop(0) bits.
module bitbang_tx_fifo
    import bitbang_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int MSB_FIRST  = 0,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 0
) (
    input  logic                          clk,
    input  logic                          TxR_n,
    input  logic                          TxC,
    input  logic                          flush,
    input  logic                          TxD_start,
    input  logic [DATA_W-1:0]             TxD_data,
    output logic                          TxD_ready,
    output logic                          TxD_busy,
    output logic                          TxD,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          ovf
);

    localparam int CW = $clog2(DATA_W) + 1;
    localparam logic [CW-1:0] LAST_D = CW'(DATA_W - 1);
    localparam logic [CW-1:0] LAST_S = CW'((STOP_BITS > 0) ? STOP_BITS - 1 : 0);

    logic              sync1_q, sync2_q, dly_q;
    logic              tick;
    logic [1:0]        state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic              par_q, par_d;
    logic              txd_q, txd_d;
    logic              ovf_q, ovf_d;
    logic              pop;
    logic              full, empty;
    logic [DATA_W-1:0] head;
    logic [15:0]       head_w;

    bitbang_fifo #(
        .W     (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (TxR_n),
        .flush_i (flush),
        .push_i  (TxD_start),
        .wdata_i (TxD_data),
        .pop_i   (pop),
        .rdata_o (head),
        .full_o  (full),
        .empty_o (empty),
        .level_o (fifo_level)
    );

    assign tick      = sync2_q & ~dly_q;
    assign TxD       = txd_q;
    assign ovf       = ovf_q;
    assign TxD_ready = ~full;
    assign TxD_busy  = (state_q != ST_IDLE) | ~empty;

    // Bring TxC into the clk domain and keep a delayed copy for edge detect.
    always_ff @(posedge clk or negedge TxR_n) begin
        if (!TxR_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            dly_q   <= 1'b0;
        end else begin
            sync1_q <= TxC;
            sync2_q <= sync1_q;
            dly_q   <= sync2_q;
        end
    end

    // Zero-extend the FIFO head for the parity helper.
    always_comb begin
        head_w = '0;
        head_w[DATA_W-1:0] = head;
    end

    // Frame sequencer: one line bit per tick, flush aborts everything.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shift_d = shift_q;
        par_d   = par_q;
        txd_d   = txd_q;
        pop     = 1'b0;
        ovf_d   = ovf_q | (TxD_start & full);
        if (flush) begin
            state_d = ST_IDLE;
            txd_d   = 1'b0;
            cnt_d   = '0;
            ovf_d   = 1'b0;
        end else if (tick) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (!empty) begin
                        pop     = 1'b1;
                        shift_d = head;
                        par_d   = parity(head_w, PARITY_ODD != 0);
                        txd_d   = 1'b1;
                        cnt_d   = '0;
                        state_d = ST_DATA;
                    end else begin
                        txd_d = 1'b0;
                    end
                end
                ST_DATA: begin
                    if (MSB_FIRST != 0) begin
                        txd_d   = shift_q[DATA_W-1];
                        shift_d = shift_q << 1;
                    end else begin
                        txd_d   = shift_q[0];
                        shift_d = shift_q >> 1;
                    end
                    if (cnt_q == LAST_D) begin
                        cnt_d = '0;
                        if (PARITY_EN != 0)
                            state_d = ST_PARITY;
                        else if (STOP_BITS > 0)
                            state_d = ST_STOP;
                        else
                            state_d = ST_IDLE;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                ST_PARITY: begin
                    txd_d   = par_q;
                    cnt_d   = '0;
                    state_d = (STOP_BITS > 0) ? ST_STOP : ST_IDLE;
                end
                ST_STOP: begin
                    txd_d = 1'b0;
                    if (cnt_q == LAST_S) begin
                        cnt_d   = '0;
                        state_d = ST_IDLE;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Sequencer and line registers.
    always_ff @(posedge clk or negedge TxR_n) begin
        if (!TxR_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            txd_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            txd_q   <= txd_d;
            ovf_q   <= ovf_d;
        end
    end

endmodule

// File: tb/tb_bitbang_tx_fifo.sv
// Directed bench for bitbang_tx_fifo across four parameter sets.
// Line bits are checked once per TxC period, after the line settles.
module tb_bitbang_tx_fifo;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       txc;
    logic       flush;
    logic [3:0] start;
    logic [7:0] data;
    logic [3:0] ready, busy, txd, ovf;
    logic [2:0] lvl0, lvl1, lvl2, lvl3;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    bitbang_tx_fifo u_d0 (
        .clk(clk), .TxR_n(rst_n), .TxC(txc), .flush(flush),
        .TxD_start(start[0]), .TxD_data(data), .TxD_ready(ready[0]),
        .TxD_busy(busy[0]), .TxD(txd[0]), .fifo_level(lvl0), .ovf(ovf[0])
    );

    bitbang_tx_fifo #(.MSB_FIRST(1)) u_d1 (
        .clk(clk), .TxR_n(rst_n), .TxC(txc), .flush(flush),
        .TxD_start(start[1]), .TxD_data(data), .TxD_ready(ready[1]),
        .TxD_busy(busy[1]), .TxD(txd[1]), .fifo_level(lvl1), .ovf(ovf[1])
    );

    bitbang_tx_fifo #(.PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(2)) u_d2 (
        .clk(clk), .TxR_n(rst_n), .TxC(txc), .flush(flush),
        .TxD_start(start[2]), .TxD_data(data), .TxD_ready(ready[2]),
        .TxD_busy(busy[2]), .TxD(txd[2]), .fifo_level(lvl2), .ovf(ovf[2])
    );

    bitbang_tx_fifo #(.PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(2)) u_d3 (
        .clk(clk), .TxR_n(rst_n), .TxC(txc), .flush(flush),
        .TxD_start(start[3]), .TxD_data(data), .TxD_ready(ready[3]),
        .TxD_busy(busy[3]), .TxD(txd[3]), .fifo_level(lvl3), .ovf(ovf[3])
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic pulse();
        @(negedge clk);
        txc = 1'b1;
        repeat (4) @(negedge clk);
        txc = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic push(input logic [3:0] which, input logic [7:0] w);
        @(negedge clk);
        start = which;
        data  = w;
        @(negedge clk);
        start = 4'b0;
    endtask

    task automatic frame(input int d, input int n, input logic [15:0] exp,
                         input string tag);
        for (int i = 0; i < n; i++) begin
            pulse();
            chk($sformatf("%s_t%0d", tag, i), 32'(txd[d]), 32'(exp[i]));
        end
    endtask

    initial begin
        rst_n = 1'b0;
        txc   = 1'b0;
        flush = 1'b0;
        start = 4'b0;
        data  = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_txd",   32'(txd[0]),   32'd0);
        chk("rst_ready", 32'(ready[0]), 32'd1);
        chk("rst_busy",  32'(busy[0]),  32'd0);
        chk("rst_level", 32'(lvl0),     32'd0);
        chk("rst_ovf",   32'(ovf[0]),   32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Default config, 0xA5 LSB first, then one idle tick.
        push(4'b0001, 8'hA5);
        chk("a5_level", 32'(lvl0),    32'd1);
        chk("a5_busy",  32'(busy[0]), 32'd1);
        frame(0, 9, 16'h014B, "a5");
        chk("a5_busy_end", 32'(busy[0]), 32'd0);
        pulse();
        chk("a5_idle", 32'(txd[0]), 32'd0);

        // MSB first, 0x01.
        push(4'b0010, 8'h01);
        frame(1, 9, 16'h0101, "msb01");
        chk("msb01_busy", 32'(busy[1]), 32'd0);

        // Parity even / odd with two stop bits, both sent together.
        push(4'b1100, 8'hA5);
        for (int i = 0; i < 12; i++) begin
            pulse();
            chk($sformatf("pev_t%0d", i), 32'(txd[2]), 32'((16'h014B >> i) & 1));
            chk($sformatf("pod_t%0d", i), 32'(txd[3]), 32'((16'h034B >> i) & 1));
        end
        chk("pev_busy", 32'(busy[2]), 32'd0);
        chk("pod_busy", 32'(busy[3]), 32'd0);

        // Fill the FIFO, overflow once, then drain back-to-back.
        push(4'b0001, 8'h11);
        push(4'b0001, 8'h22);
        push(4'b0001, 8'h33);
        chk("fill3_ready", 32'(ready[0]), 32'd1);
        push(4'b0001, 8'h44);
        chk("fill4_ready", 32'(ready[0]), 32'd0);
        chk("fill4_level", 32'(lvl0),     32'd4);
        chk("fill4_ovf",   32'(ovf[0]),   32'd0);
        push(4'b0001, 8'h55);
        chk("ovf_set",   32'(ovf[0]), 32'd1);
        chk("ovf_level", 32'(lvl0),   32'd4);
        frame(0, 9, 16'h0023, "b2b11");
        frame(0, 9, 16'h0045, "b2b22");
        frame(0, 9, 16'h0067, "b2b33");
        frame(0, 9, 16'h0089, "b2b44");
        chk("b2b_level", 32'(lvl0),    32'd0);
        chk("b2b_busy",  32'(busy[0]), 32'd0);
        chk("b2b_ovf",   32'(ovf[0]),  32'd1);

        // Flush mid-frame; a same-cycle push is discarded.
        push(4'b0001, 8'h3C);
        frame(0, 4, 16'h0009, "pre_fl");
        @(negedge clk);
        flush = 1'b1;
        start = 4'b0001;
        data  = 8'hEE;
        @(negedge clk);
        flush = 1'b0;
        start = 4'b0;
        chk("fl_txd",   32'(txd[0]),  32'd0);
        chk("fl_level", 32'(lvl0),    32'd0);
        chk("fl_ovf",   32'(ovf[0]),  32'd0);
        chk("fl_busy",  32'(busy[0]), 32'd0);
        push(4'b0001, 8'h81);
        frame(0, 9, 16'h0103, "post81");

        // Asynchronous reset while a frame runs and the FIFO is full.
        push(4'b0001, 8'h0F);
        push(4'b0001, 8'h1E);
        push(4'b0001, 8'h2D);
        push(4'b0001, 8'h4B);
        pulse();
        chk("ar_start", 32'(txd[0]), 32'd1);
        chk("ar_lvl3",  32'(lvl0),   32'd3);
        push(4'b0001, 8'h5A);
        push(4'b0001, 8'h69);
        chk("ar_ready0", 32'(ready[0]), 32'd0);
        chk("ar_ovf1",   32'(ovf[0]),   32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_txd",   32'(txd[0]),   32'd0);
        chk("ar_busy",  32'(busy[0]),  32'd0);
        chk("ar_ready", 32'(ready[0]), 32'd1);
        chk("ar_level", 32'(lvl0),     32'd0);
        chk("ar_ovf",   32'(ovf[0]),   32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        pulse();
        chk("ar_after", 32'(txd[0]), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
